fly_out_animator: RTL and testbench
===================================

// Module: fly_out_animator
// PURPOSE
// - Companion to the fly-in animation. Moves the 4x4 fly from its landing fruit back out to
//   the left screen edge (x=0).
// - Emits VGA pixel writes (x, y, colour, plot) on the same rail as the fly-in block.
// - On each step it erases the fly by restoring pixels from the background ROM, then redraws
//   it 1 px further left.
// - Raises over when the fly has left the screen. The top-level game FSM sequences it.
// PARAMETERS
// - HOLD_CYCLES  150000  cycles the fly stays visible per position (sets flight speed)
// - FLY_Y        165     top row of the fly (constant for the whole flight)
// - SCREEN_W     320     background ROM row pitch, in pixels
// - FLY_COLOUR   3'b000  colour of drawn fly pixels
// - X_A/X_B/X_C/X_D  50/125/200/275  landing x of fruit for address 0/1/2/3
// PORTS
// - clock      in   1   CLOCK_50; everything is rising-edge
// - reset      in   1   synchronous, active-high
// - start      in   1   begin fly-out; sampled in IDLE only
// - address    in   2   fruit the fly leaves from; latched in LOAD
// - bg_addr    out  17  background ROM read address (combinational)
// - bg_colour  in   3   ROM data; valid 1 cycle after bg_addr (synchronous ROM)
// - x          out  9   pixel x (registered)
// - y          out  8   pixel y (registered)
// - colour     out  3   pixel colour (registered)
// - plot       out  1   pixel write strobe (registered); one pixel per high cycle
// - over       out  1   high in DONE
// BEHAVIOUR
// - Reset (any cycle, including mid-flight): state=IDLE next cycle.
//   x, y, colour, plot, over, fx and counters all 0. bg_addr=0 outside ERASE.
// - fx (9 b) is the fly's left column. Fly pixel k (k=0..15): col=k[1:0], row=k[3:2];
//   it is plotted at (fx+col, FLY_Y+row).
// - States:
//   - IDLE: start=1 -> LOAD.
//   - LOAD (1 cycle): fx <= X_[address] -> HOLD. The fly-in block has already drawn the fly
//     here, so the first action is HOLD, not DRAW.
//   - DRAW (16 cycles, k=0..15): one cycle after count k, plot=1, x=fx+col, y=FLY_Y+row,
//     colour=FLY_COLOUR. k=15 -> HOLD.
//   - HOLD: count 0..HOLD_CYCLES-1, plot=0. Exits after exactly HOLD_CYCLES cycles -> ERASE.
//   - ERASE (17 cycles, e=0..16):
//     - e<16: bg_addr=(FLY_Y+row(e))*SCREEN_W + fx + col(e).
//     - Pixel e is plotted 2 cycles after its address issue, with colour=bg_colour and x/y
//       delayed to match. The 16 erase plots are contiguous.
//     - The last erase plot lands in the cycle after ERASE exits.
//     - Exit at e=16: fx==0 -> DONE, else -> STEP.
//   - STEP (1 cycle): fx <= fx-1 -> DRAW. No wrap: fx never decrements below 0.
//   - DONE: over=1, plot=0 after the final erase plot. start=0 -> IDLE (over=0 next cycle).
//     Stays in DONE while start=1.
// - start and address are ignored outside IDLE and LOAD respectively. Toggling either
//   mid-flight has no effect.
// - Only DRAW and ERASE (plus the one-cycle erase tail) assert plot. No plot in HOLD, STEP,
//   LOAD, IDLE or DONE.
// - Width: bg_addr maximum (168*320+319)=54079 < 2^17. Compute at 17 b; no truncation.
// - Flight from fruit X: X erase bursts + X draw bursts + one final erase (X+1 erases total).
// TESTING
// - Reset/idle: assert reset, then IDLE with start=0 for 10 cycles -> plot=0, over=0,
//   x=y=colour=0 throughout.
// - address=2'b11, HOLD_CYCLES=4, pulse start:
//   - first plot burst is 16 erase pixels at x=275..278, y=165..168;
//   - first bg_addr=53075;
//   - each colour equals the ROM value for its address.
// - address=2'b00, HOLD_CYCLES=4: exactly 50 draw bursts and 51 erase bursts. First draw at
//   x=49..52. Final erase at x=0..3, y=165..168, then over=1.
// - Draw ordering at fx=49: plots in order (49,165)(50,165)(51,165)(52,165)(49,166)...(52,168),
//   all colour=000, 16 consecutive cycles.
// - Mid-flight robustness: change address and drop/raise start during HOLD -> trajectory
//   unchanged. Assert reset during ERASE -> next cycle plot=0, over=0, state IDLE; restart
//   works normally.
// - Completion handshake: hold start=1 after over -> over stays 1, no plots. Drop start ->
//   over=0 next cycle. Re-pulse start with address=2'b01 -> flight restarts from x=125.

Source files
------------

// File: rtl/fly_out_animator.sv
// Flies the 4x4 fly from its landing fruit back to x=0, restoring the background behind it
// one step at a time and redrawing it 1 px further left on each step.
module fly_out_animator #(
  parameter int         HOLD_CYCLES = 150000,
  parameter int         FLY_Y       = 165,
  parameter int         SCREEN_W    = 320,
  parameter logic [2:0] FLY_COLOUR  = 3'b000,
  parameter int         X_A         = 50,
  parameter int         X_B         = 125,
  parameter int         X_C         = 200,
  parameter int         X_D         = 275
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  address,
  output logic [16:0] bg_addr,
  input  logic [2:0]  bg_colour,
  output logic [8:0]  x,
  output logic [7:0]  y,
  output logic [2:0]  colour,
  output logic        plot,
  output logic        over
);

  // Counter must reach 16 for ERASE as well as HOLD_CYCLES-1 for HOLD.
  localparam int CNT_W = (HOLD_CYCLES > 17) ? $clog2(HOLD_CYCLES) : 5;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] DRAW_LAST  = CNT_W'(15);
  localparam logic [CNT_W-1:0] ERASE_LAST = CNT_W'(16);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_DRAW, S_HOLD, S_ERASE, S_STEP, S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [8:0]       fx, fx_nxt;
  logic [8:0]       px;
  logic [7:0]       py;
  logic             erase_issue;
  logic             vld_p0;
  logic [8:0]       x_p0;
  logic [7:0]       y_p0;

  function automatic logic [8:0] start_x(input logic [1:0] a);
    case (a)
      2'd0:    return 9'(X_A);
      2'd1:    return 9'(X_B);
      2'd2:    return 9'(X_C);
      default: return 9'(X_D);
    endcase
  endfunction

  function automatic logic [16:0] bg_index(input logic [7:0] row_y, input logic [8:0] col_x);
    return 17'(row_y) * 17'(SCREEN_W) + 17'(col_x);
  endfunction

  // Pixel k of the fly sits at column k[1:0], row k[3:2] relative to (fx, FLY_Y).
  assign px          = fx + {7'd0, cnt[1:0]};
  assign py          = 8'(FLY_Y) + {6'd0, cnt[3:2]};
  assign erase_issue = (state == S_ERASE) && !cnt[4];
  assign bg_addr     = erase_issue ? bg_index(py, px) : 17'd0;
  assign over        = (state == S_DONE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      fx    <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      fx    <= fx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    fx_nxt    = fx;
    case (state)
      S_IDLE: if (start) state_nxt = S_LOAD;
      // The fly-in block left the fly drawn at the fruit, so the first move is a hold.
      S_LOAD: begin
        fx_nxt    = start_x(address);
        cnt_nxt   = '0;
        state_nxt = S_HOLD;
      end
      S_DRAW: begin
        if (cnt == DRAW_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_HOLD;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt == HOLD_LAST) begin
          cnt_nxt   = '0;
          state_nxt = S_ERASE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      S_ERASE: begin
        if (cnt == ERASE_LAST) begin
          cnt_nxt   = '0;
          state_nxt = (fx == 9'd0) ? S_DONE : S_STEP;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      // Only reached with fx > 0, so the decrement never wraps.
      S_STEP: begin
        fx_nxt    = fx - 9'd1;
        state_nxt = S_DRAW;
      end
      S_DONE:  if (!start) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Stage p0: erase coordinates wait one cycle for the synchronous ROM read.
  always_ff @(posedge clock) begin
    if (reset) vld_p0 <= 1'b0;
    else       vld_p0 <= erase_issue;
  end

  always_ff @(posedge clock) begin
    if (erase_issue) begin
      x_p0 <= px;
      y_p0 <= py;
    end
  end

  // Stage p1: registered pixel rail, fed by DRAW directly or by the erase pipe.
  always_ff @(posedge clock) begin
    if (reset) begin
      plot   <= 1'b0;
      x      <= '0;
      y      <= '0;
      colour <= '0;
    end else if (state == S_DRAW) begin
      plot   <= 1'b1;
      x      <= px;
      y      <= py;
      colour <= FLY_COLOUR;
    end else begin
      plot <= vld_p0;
      if (vld_p0) begin
        x      <= x_p0;
        y      <= y_p0;
        colour <= bg_colour;
      end
    end
  end

endmodule

// File: tb/tb_fly_out_animator.sv
// Randomised bench for fly_out_animator: a pixel-list model of each flight is compared
// against every plotted pixel, with literal pins on coordinates, addresses and burst counts.
module tb_fly_out_animator;

  logic        clock = 1'b0;
  logic        reset, start;
  logic [1:0]  address;
  logic [16:0] bg_addr;
  logic [2:0]  bg_colour;
  logic [8:0]  x;
  logic [7:0]  y;
  logic [2:0]  colour;
  logic        plot, over;

  fly_out_animator #(.HOLD_CYCLES(4)) dut (
    .clock(clock), .reset(reset), .start(start), .address(address),
    .bg_addr(bg_addr), .bg_colour(bg_colour), .x(x), .y(y), .colour(colour),
    .plot(plot), .over(over)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [8:0] x;
    logic [7:0] y;
    logic [2:0] c;
    logic       draw;
  } pix_t;

  pix_t expq[$];
  int   checks = 0, failures = 0;
  int   flight_id = 0;
  bit   abort = 1'b0;
  int   XS[4] = '{50, 125, 200, 275};

  int   seen_id = 0, run_len = 0, runs = 0;
  bit   got_first = 0, got_draw = 0, got_addr = 0;
  int   first_x, first_y, draw_x, draw_y, last_x, last_y, first_addr;

  function automatic logic [2:0] rom(input int a);
    int h;
    h = a * 5 + (a >> 3) + (a >> 7);
    return h[2:0];
  endfunction

  // Synchronous background ROM: data appears one clock after the address.
  always @(posedge clock) bg_colour <= rom(int'(bg_addr));

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // A flight from xs: erase at every fx from xs down to 0, and draw at fx-1 after each
  // erase except the last.
  task automatic build(input int xs);
    expq.delete();
    for (int fx = xs; fx >= 0; fx--) begin
      for (int k = 0; k < 16; k++) begin
        int px = fx + k % 4;
        int py = 165 + k / 4;
        expq.push_back('{x: 9'(px), y: 8'(py), c: rom(py * 320 + px), draw: 1'b0});
      end
      if (fx > 0) begin
        for (int k = 0; k < 16; k++)
          expq.push_back('{x: 9'(fx - 1 + k % 4), y: 8'(165 + k / 4), c: 3'b000, draw: 1'b1});
      end
    end
  endtask

  always @(negedge clock) begin
    pix_t e;
    if (flight_id != seen_id) begin
      seen_id   = flight_id;
      run_len   = 0;
      runs      = 0;
      got_first = 0;
      got_draw  = 0;
      got_addr  = 0;
    end
    if (!reset) begin
      if (bg_addr != 17'd0 && !got_addr) begin
        got_addr   = 1;
        first_addr = int'(bg_addr);
      end
      if (plot) begin
        chk("plot_expected", int'(expq.size() > 0), 1);
        if (expq.size() > 0) begin
          e = expq.pop_front();
          chk(e.draw ? "draw_pixel_xyc" : "erase_pixel_xyc",
              int'({x, y, colour}), int'({e.x, e.y, e.c}));
          if (!got_first) begin
            got_first = 1;
            first_x   = int'(x);
            first_y   = int'(y);
          end
          if (e.draw && !got_draw) begin
            got_draw = 1;
            draw_x   = int'(x);
            draw_y   = int'(y);
          end
          last_x = int'(x);
          last_y = int'(y);
        end
        run_len++;
      end else if (run_len > 0) begin
        if (!abort) chk("burst_len", run_len, 16);
        runs++;
        run_len = 0;
      end
    end
  end

  task automatic flight(input int a, input bit hold, input bit perturb);
    int n = 0;
    build(XS[a]);
    flight_id++;
    address = 2'(a);
    start   = 1'b1;
    tick();
    if (!hold) start = 1'b0;
    while (!over && n < 30000) begin
      if (perturb && n > 2) begin
        address = 2'($urandom);
        start   = 1'($urandom);
      end
      tick();
      n++;
    end
    chk("over_reached", int'(over), 1);
    if (!hold) start = 1'b0;
    tick();
    if (hold) begin
      repeat (20) begin
        tick();
        chk("done_holds_over_no_plot", int'({over, plot}), 2);
      end
      start = 1'b0;
      tick();
      chk("over_clears", int'(over), 0);
    end else begin
      tick();
    end
    chk("model_drained", expq.size(), 0);
  endtask

  initial begin
    int n;
    int a;
    reset   = 1'b1;
    start   = 1'b0;
    address = 2'd0;
    repeat (3) tick();
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_outputs", int'({plot, over, x, y, colour}), 0);
    end

    // Fruit 3 with start/address scrambled mid-flight.
    flight(3, 1'b0, 1'b1);
    chk("a_first_x", first_x, 275);
    chk("a_first_y", first_y, 165);
    chk("a_first_bg_addr", first_addr, 53075);
    chk("a_bursts", runs, 551);

    // Fruit 0 with start held through completion.
    flight(0, 1'b1, 1'b0);
    chk("b_first_draw_x", draw_x, 49);
    chk("b_first_draw_y", draw_y, 165);
    chk("b_last_x", last_x, 3);
    chk("b_last_y", last_y, 168);
    chk("b_bursts", runs, 101);

    flight(1, 1'b0, 1'b0);
    chk("d_first_x", first_x, 125);
    chk("d_bursts", runs, 251);

    // Reset in the middle of an erase burst.
    build(275);
    flight_id++;
    address = 2'd3;
    start   = 1'b1;
    tick();
    start = 1'b0;
    n = 0;
    while (bg_addr == 17'd0 && n < 200) begin
      tick();
      n++;
    end
    chk("c_erase_reached", int'(bg_addr != 17'd0), 1);
    repeat ($urandom_range(2, 12)) tick();
    abort = 1'b1;
    reset = 1'b1;
    tick();
    chk("c_reset_plot", int'(plot), 0);
    chk("c_reset_over", int'(over), 0);
    chk("c_reset_bg_addr", int'(bg_addr), 0);
    reset = 1'b0;
    expq.delete();
    flight_id++;
    tick();
    abort = 1'b0;

    a = int'($urandom_range(0, 3));
    flight(a, 1'b0, 1'b1);
    chk("e_first_x", first_x, XS[a]);
    chk("e_bursts", runs, 2 * XS[a] + 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
